// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Serial adder that processes one 4-bit nibble per clock, LSB first, with a
// single shared 4-bit adder. A three-state FSM (IDLE/RUN/DONE) sequences the
// operation. sum and c_out only change at completion, so intermediate nibbles
// are never visible.
//
// Optional feature: define NIBBLE_SERIAL_ADDER_SUB_EN to add the 'sub' input.
// With sub=1 the captured B operand is inverted and the initial carry is
// forced to 1, giving a - b modulo 2^W (c_out=1 means no borrow).
//
// Handshake: a start is accepted on a rising edge whenever ready is high
// (state IDLE or DONE); starts while busy (RUN) are ignored. done is a
// one-cycle pulse in the cycle when the new sum/c_out first appear.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic                   sub,
`endif
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     acc_q;
  logic             carry_q;
  logic [W-1:0]     sum_q;
  logic             c_out_q;

  logic             accept;
  logic [W-1:0]     b_eff;
  logic             cin_eff;
  logic [4:0]       nib_sum;
  logic [W-1:0]     acc_merged;

  // A start is taken whenever the FSM is not in the middle of a run
  assign accept = start && (state_q != RUN);

  // Operand conditioning at capture: add passes b/c_in, subtract uses ~b and carry 1
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  always_comb begin
    b_eff   = b;
    cin_eff = c_in;
    if (sub) begin
      b_eff   = ~b;
      cin_eff = 1'b1;
    end
  end
`else
  always_comb begin
    b_eff   = b;
    cin_eff = c_in;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN lasts exactly NIBBLES cycles, DONE can restart directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared nibble adder and the accumulator with the current nibble merged in
  always_comb begin
    nib_sum    = {1'b0, a_q[idx_q*4 +: 4]} + {1'b0, b_q[idx_q*4 +: 4]} + {4'b0000, carry_q};
    acc_merged = acc_q;
    acc_merged[idx_q*4 +: 4] = nib_sum[3:0];
  end

  // Datapath: capture on accept, one nibble per RUN cycle, publish on the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_eff;
      carry_q <= cin_eff;
      acc_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= acc_merged;
      carry_q <= nib_sum[4];
      idx_q   <= idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        sum_q   <= acc_merged;
        c_out_q <= nib_sum[4];
      end
    end
  end

  // Status outputs decode directly from the state register
  assign busy  = (state_q == RUN);
  assign ready = !busy;
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed and randomized stimulus,
// expected {c_out,sum} and completion edge queued at accept time by a
// plain-arithmetic model, popped and compared by a negedge monitor.
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub_v = 1'b0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub   (sub_v),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q[$];
  int         exp_edge_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         edge_no  = 0;
  bit         have_acc = 1'b0;
  int         last_acc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, expv, edge_no);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs, then model acceptance at the following edge.
  task automatic step(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic sb);
    logic [W:0] r;
    start = st; a = av; b = bv; c_in = ci; sub_v = sb;
    @(posedge clk);
    edge_no++;
    if (st && (!have_acc || edge_no > last_acc + NIBBLES)) begin
      if (SUB_ON && sub_v)
        r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
      else
        r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
      exp_q.push_back(r);
      exp_edge_q.push_back(edge_no + NIBBLES);
      have_acc = 1'b1;
      last_acc = edge_no;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sum"},   64'(sum),   64'(0));
    chk({tag, "_c_out"}, 64'(c_out), 64'(0));
    chk({tag, "_done"},  64'(done),  64'(0));
    chk({tag, "_busy"},  64'(busy),  64'(0));
    chk({tag, "_ready"}, 64'(ready), 64'(1));
  endtask

  // Assert reset mid-cycle, check outputs right away, drop model state.
  task automatic do_reset(input string tag);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    exp_edge_q.delete();
    have_acc = 1'b0;
    repeat (2) begin
      @(posedge clk);
      edge_no++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic busy_exp;
      busy_exp = have_acc && (edge_no >= last_acc) && (edge_no < last_acc + NIBBLES);
      chk("ready_vs_busy", 64'(ready), 64'(!busy));
      chk("busy", 64'(busy), 64'(busy_exp));
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion (edge %0d)", edge_no);
        end else begin
          logic [W:0] e;
          int         ee;
          e  = exp_q.pop_front();
          ee = exp_edge_q.pop_front();
          chk("sum",       64'(sum),     64'(e[W-1:0]));
          chk("c_out",     64'(c_out),   64'(e[W]));
          chk("done_edge", 64'(edge_no), 64'(ee));
        end
      end else if (exp_edge_q.size() > 0 && exp_edge_q[0] <= edge_no) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_done: got done=0 expected done at edge %0d (edge %0d)",
                 exp_edge_q[0], edge_no);
        void'(exp_q.pop_front());
        void'(exp_edge_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Power-on reset
    #1;
    check_reset_outputs("por");
    repeat (2) begin
      @(posedge clk);
      edge_no++;
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: accepted at the first edge after reset release
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
    idle(NIBBLES + 1);
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    idle(NIBBLES + 1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    idle(NIBBLES + 1);

    // Start held high with operands changing every cycle: back-to-back runs
    for (int i = 0; i < 4 * (NIBBLES + 1); i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    idle(NIBBLES + 1);

    // Reset during the second RUN cycle: outputs clear at once, no done follows
    step(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    do_reset("midrun");
    idle(2 * NIBBLES);
    chk("sum_after_abort",   64'(sum),   64'(0));
    chk("c_out_after_abort", 64'(c_out), 64'(0));

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    step(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1);
    idle(NIBBLES + 1);
    step(1'b1, 16'h0007, 16'h0005, 1'b0, 1'b1);
    idle(NIBBLES + 1);
`endif

    // Randomized traffic with sparse and dense starts
    for (int i = 0; i < 300; i++) begin
      logic sb;
      sb = SUB_ON ? 1'($urandom) : 1'b0;
      step(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom), sb);
    end

    // Drain outstanding results with a bounded wait
    for (int i = 0; i < 4 * NIBBLES && exp_q.size() > 0; i++) idle(1);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
